// File: rtl/multi_shape_processor.sv
// Multi-channel shape/operation SFR slave with per-channel fixed-latency
// operation FSM, registered read-back, error pulse and read-to-clear sticky error.
module multi_shape_processor #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned OP_LATENCY   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [31:0]             write_data,
    input  logic                    read,
    output logic [31:0]             read_data,
    output logic                    error,
    output logic [NUM_CHANNELS-1:0] done
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam logic [ADDR_WIDTH:0] LP_NCH      = (ADDR_WIDTH + 1)'(NUM_CHANNELS);
    localparam logic [7:0]          LP_CNT_INIT = 8'(OP_LATENCY - 1);

    state_t            r_state     [NUM_CHANNELS];
    state_t            w_state_nxt [NUM_CHANNELS];
    logic [7:0]        r_cnt       [NUM_CHANNELS];
    logic [7:0]        w_cnt_nxt   [NUM_CHANNELS];
    logic [1:0]        r_shape     [NUM_CHANNELS];
    logic [4:0]        r_op        [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_err, w_err_nxt;
    logic [NUM_CHANNELS-1:0] r_done, w_done_nxt;
    logic [31:0]       r_rd_data, w_rd_data;
    logic              r_error;

    logic [1:0]        w_shape;
    logic [4:0]        w_op;
    logic              w_start;
    logic              w_in_range, w_shape_ok, w_op_ok, w_sel_busy;
    logic              w_wr_acc, w_wr_rej, w_rd_rej;
    logic              w_unused_bits;

    assign w_shape       = write_data[17:16];
    assign w_op          = write_data[4:0];
    assign w_start       = write_data[31];
    assign w_unused_bits = ^{write_data[30:18], write_data[15:5]};

    assign w_in_range = ({1'b0, address} < LP_NCH);
    assign w_shape_ok = ^w_shape;
    assign w_op_ok    = (w_op == 5'd0) || (w_op == 5'd1) || (w_op == 5'd8) ||
                        (w_op == 5'd16) || (w_op == 5'd17);
    assign w_wr_acc   = write && w_in_range && w_shape_ok && w_op_ok && !w_sel_busy;
    assign w_wr_rej   = write && !w_wr_acc;
    assign w_rd_rej   = read && !w_in_range;

    // Out-of-range addresses match no channel, so the read mux yields zero.
    always_comb begin
        w_sel_busy = 1'b0;
        w_rd_data  = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (address == ADDR_WIDTH'(i)) begin
                w_sel_busy = (r_state[i] == ST_BUSY);
                w_rd_data  = {(r_state[i] == ST_BUSY), r_err[i], 12'b0,
                              r_shape[i], 11'b0, r_op[i]};
            end
        end
    end

    always_comb begin
        w_err_nxt  = r_err;
        w_done_nxt = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_wr_acc && w_start && (address == ADDR_WIDTH'(i))) begin
                        w_state_nxt[i] = ST_BUSY;
                        w_cnt_nxt[i]   = LP_CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt[i] == '0) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_done_nxt[i]  = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
            // A rejected write sets the flag even when a read would clear it.
            if (w_wr_rej && w_in_range && (address == ADDR_WIDTH'(i))) begin
                w_err_nxt[i] = 1'b1;
            end else if (read && (address == ADDR_WIDTH'(i))) begin
                w_err_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_shape[i] <= 2'b01;
                r_op[i]    <= '0;
            end
            r_err     <= '0;
            r_done    <= '0;
            r_rd_data <= '0;
            r_error   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                if (w_wr_acc && (address == ADDR_WIDTH'(i))) begin
                    r_shape[i] <= w_shape;
                    r_op[i]    <= w_op;
                end
            end
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_wr_rej || w_rd_rej;
            if (read) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

    assign read_data = r_rd_data;
    assign error     = r_error;
    assign done      = r_done;

endmodule

// File: tb/tb_multi_shape_processor.sv
// Scoreboard bench for multi_shape_processor: stimulus queues expected bus
// responses and done pulses per clock edge; a monitor pops and compares them.
module tb_multi_shape_processor;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [3:0]  address;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        error;
    logic [3:0]  done;

    multi_shape_processor #(
        .NUM_CHANNELS(4),
        .ADDR_WIDTH  (4),
        .OP_LATENCY  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .write     (write),
        .address   (address),
        .write_data(write_data),
        .read      (read),
        .read_data (read_data),
        .error     (error),
        .done      (done)
    );

    typedef struct {
        int          edge_n;
        logic        rd;
        logic [31:0] val;
        logic        err;
        string       tag;
    } bus_exp_t;

    typedef struct {
        int         edge_n;
        logic [3:0] mask;
    } done_exp_t;

    bus_exp_t  sb[$];
    done_exp_t dq[$];
    int        cyc = 0;
    int        last_edge = 0;
    int        n_cmp = 0;
    int        n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: inputs change just after an edge and are captured by the next edge.
    task automatic bus(input logic w, input logic r, input logic [3:0] a,
                       input logic [31:0] d, input logic ee, input logic [31:0] ev,
                       input string tag);
        bus_exp_t e;
        @(posedge clk);
        #1;
        write      = w;
        read       = r;
        address    = a;
        write_data = d;
        last_edge  = cyc + 1;
        if (w || r) begin
            e.edge_n = last_edge;
            e.rd     = r;
            e.val    = ev;
            e.err    = ee;
            e.tag    = tag;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, "idle");
    endtask

    initial begin : monitor
        bus_exp_t  e;
        done_exp_t de;
        logic [3:0] exp_done;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].edge_n == cyc) begin
                e = sb.pop_front();
                chk({e.tag, " error"}, {31'd0, error}, {31'd0, e.err});
                if (e.rd) chk({e.tag, " read_data"}, read_data, e.val);
            end else begin
                chk("quiet error", {31'd0, error}, 32'd0);
            end
            exp_done = 4'd0;
            if (dq.size() > 0 && dq[0].edge_n == cyc) begin
                de = dq.pop_front();
                exp_done = de.mask;
            end
            chk("done", {28'd0, done}, {28'd0, exp_done});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        done_exp_t de;
        rst_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; write_data = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset read_data", read_data, 32'd0);
        chk("reset error", {31'd0, error}, 32'd0);
        chk("reset done", {28'd0, done}, 32'd0);
        rst_n = 1'b1;

        bus(0, 1, 4'd0, 32'h0, 0, 32'h0001_0000, "rd ch0 reset");
        bus(1, 0, 4'd1, 32'h0002_0011, 0, 32'h0, "wr ch1 legal");
        bus(0, 1, 4'd1, 32'h0, 0, 32'h0002_0011, "rd ch1");
        bus(1, 0, 4'd2, 32'h0003_0001, 1, 32'h0, "wr ch2 shape11");
        bus(1, 0, 4'd2, 32'h0001_0018, 1, 32'h0, "wr ch2 op24");
        bus(0, 1, 4'd2, 32'h0, 0, 32'h4001_0000, "rd ch2 sticky");
        bus(0, 1, 4'd2, 32'h0, 0, 32'h0001_0000, "rd ch2 cleared");

        // ch0 start with latency 3: busy through edges E0+1..E0+3, done after E0+3
        bus(1, 0, 4'd0, 32'h8001_0008, 0, 32'h0, "wr ch0 start");
        de.edge_n = last_edge + 3; de.mask = 4'b0001; dq.push_back(de);
        bus(1, 0, 4'd1, 32'h0001_0001, 0, 32'h0, "wr ch1 during ch0 busy");
        bus(0, 1, 4'd0, 32'h0, 0, 32'h8001_0008, "rd ch0 busy");
        bus(1, 1, 4'd0, 32'h0001_0000, 1, 32'h8001_0008, "rd+wr ch0 busy");
        bus(0, 1, 4'd0, 32'h0, 0, 32'h4001_0008, "rd ch0 idle sticky");
        bus(0, 1, 4'd1, 32'h0, 0, 32'h0001_0001, "rd ch1 updated");
        bus(0, 1, 4'd0, 32'h0, 0, 32'h0001_0008, "rd ch0 cleared");

        bus(1, 1, 4'd2, 32'h0001_0002, 1, 32'h0001_0000, "rd+wr ch2 bad op");
        bus(0, 1, 4'd2, 32'h0, 0, 32'h4001_0000, "rd ch2 set wins");
        bus(1, 0, 4'd1, 32'h8003_0000, 1, 32'h0, "wr ch1 start illegal");
        bus(0, 1, 4'd1, 32'h0, 0, 32'h4001_0001, "rd ch1 not started");

        bus(1, 0, 4'd4, 32'h0001_0000, 1, 32'h0, "wr oob");
        bus(0, 1, 4'd4, 32'h0, 1, 32'h0, "rd oob");
        bus(1, 1, 4'd4, 32'h0001_0001, 1, 32'h0, "rd+wr oob");
        bus(0, 1, 4'd0, 32'h0, 0, 32'h0001_0008, "rd ch0 after oob");
        bus(0, 1, 4'd2, 32'h0, 0, 32'h0001_0000, "rd ch2 after oob");
        bus(0, 1, 4'd3, 32'h0, 0, 32'h0001_0000, "rd ch3 after oob");

        bus(1, 0, 4'd3, 32'h8002_0010, 0, 32'h0, "wr ch3 start");
        idle(1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midop reset read_data", read_data, 32'd0);
        chk("midop reset error", {31'd0, error}, 32'd0);
        chk("midop reset done", {28'd0, done}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        bus(0, 1, 4'd3, 32'h0, 0, 32'h0001_0000, "rd ch3 after reset");
        bus(0, 1, 4'd0, 32'h0, 0, 32'h0001_0000, "rd ch0 after reset");
        idle(6);

        chk("scoreboard drained", sb.size(), 32'd0);
        chk("done queue drained", dq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
